// File: rtl/bus_xfer_mux.sv
// Single-slave transfer stage behind the bus arbiter: latches the granted master's command,
// runs a valid/ready handshake to the slave and pulses completion back. Optional macro: BUS_XFER_TIMEOUT_EN.
module bus_xfer_mux #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           grant,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]           m_we,
  output logic [NUM_MASTERS-1:0]           m_done,
  output logic [NUM_MASTERS-1:0]           m_err,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             s_valid,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic                             s_we,
  input  logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  output logic                             busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        sel_idx_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    sel_we_s;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_xfer_mux: TIMEOUT_CYCLES must be within 1..255");
  end

  // Lowest set grant bit owns the transfer; extra grant bits are silently dropped.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MASTERS-1:0] g);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (g[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_MASTERS-1:0] r;
    r    = {NUM_MASTERS{1'b0}};
    r[i] = 1'b1;
    return r;
  endfunction

  // Select the command of the winning master from the flattened buses.
  always_comb begin
    sel_idx_s   = lowest_idx(grant);
    sel_addr_s  = m_addr[sel_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata_s = m_wdata[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
    sel_we_s    = m_we[sel_idx_s];
  end

`ifdef BUS_XFER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_r;
`else
  assign m_err = {NUM_MASTERS{1'b0}};
`endif

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      s_valid    <= 1'b0;
      s_addr     <= {ADDR_WIDTH{1'b0}};
      s_wdata    <= {DATA_WIDTH{1'b0}};
      s_we       <= 1'b0;
      m_done     <= {NUM_MASTERS{1'b0}};
      m_rdata    <= {DATA_WIDTH{1'b0}};
      busy       <= 1'b0;
`ifdef BUS_XFER_TIMEOUT_EN
      m_err      <= {NUM_MASTERS{1'b0}};
      wait_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant) begin
            state_r    <= REQ;
            idx_r      <= sel_idx_s;
            s_addr     <= sel_addr_s;
            s_wdata    <= sel_wdata_s;
            s_we       <= sel_we_s;
            s_valid    <= 1'b1;
            busy       <= 1'b1;
`ifdef BUS_XFER_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (s_ready) begin
            s_valid <= 1'b0;
            m_done  <= onehot(idx_r);
            if (!s_we) begin
              m_rdata <= s_rdata;
            end else begin
              m_rdata <= m_rdata;
            end
            state_r <= RESP;
          end
`ifdef BUS_XFER_TIMEOUT_EN
          // Compare against TIMEOUT-1 so the edge that would reach the limit is the abort edge.
          else if (wait_cnt_r == TO_LAST) begin
            s_valid <= 1'b0;
            m_done  <= onehot(idx_r);
            m_err   <= onehot(idx_r);
            m_rdata <= {DATA_WIDTH{1'b1}};
            state_r <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
`else
          else begin
            state_r <= REQ;
          end
`endif
        end
        RESP: begin
          m_done  <= {NUM_MASTERS{1'b0}};
`ifdef BUS_XFER_TIMEOUT_EN
          m_err   <= {NUM_MASTERS{1'b0}};
`endif
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          s_valid <= 1'b0;
          m_done  <= {NUM_MASTERS{1'b0}};
`ifdef BUS_XFER_TIMEOUT_EN
          m_err   <= {NUM_MASTERS{1'b0}};
`endif
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_mux.sv
// Self-checking bench for bus_xfer_mux: directed scenarios plus randomized transfers
// compared against a transaction-level model.
module tb_bus_xfer_mux;
  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef BUS_XFER_TIMEOUT_EN
  localparam int TO        = 4;
  localparam int LONG_WAIT = 3;
`else
  localparam int TO        = 15;
  localparam int LONG_WAIT = 4;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    grant;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_we;
  logic [NM-1:0]    m_done;
  logic [NM-1:0]    m_err;
  logic [DW-1:0]    m_rdata;
  logic             s_valid;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_we;
  logic             s_ready;
  logic [DW-1:0]    s_rdata;
  logic             busy;

  logic [AW-1:0] addr_a  [NM];
  logic [DW-1:0] wdata_a [NM];
  logic [DW-1:0] model_rdata;
  int n_cmp = 0;
  int n_bad = 0;

  bus_xfer_mux #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .grant(grant), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata), .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_we(s_we), .s_ready(s_ready), .s_rdata(s_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW]  = addr_a[i];
      m_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner = lowest set bit, isolated arithmetically as g & -g.
  function automatic int low_idx(input logic [NM-1:0] g);
    logic [NM-1:0] iso;
    iso = g & (~g + 4'd1);
    return $clog2(iso);
  endfunction

  function automatic logic [NM-1:0] bit_of(input int i);
    logic [NM-1:0] r;
    r = 4'd1 << i;
    return r;
  endfunction

  task automatic scramble_masters();
    for (int i = 0; i < NM; i++) begin
      addr_a[i]  = 16'($urandom);
      wdata_a[i] = $urandom;
      m_we[i]    = 1'($urandom_range(0, 1));
    end
  endtask

  // One full transfer starting in IDLE; ends with the FSM back in IDLE.
  task automatic xfer(input logic [NM-1:0] g, input int waits, input logic [DW-1:0] rd,
                      input logic [NM-1:0] grant_in_req);
    int            idx;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewe;
    idx = low_idx(g);
    ea  = addr_a[idx];
    ew  = wdata_a[idx];
    ewe = m_we[idx];
    s_ready = 1'b0;
    grant   = g;
    tick();
    grant = grant_in_req;
    scramble_masters();
    check("req_valid", s_valid, 1);
    check("req_busy", busy, 1);
    check("req_addr", s_addr, ea);
    check("req_wdata", s_wdata, ew);
    check("req_we", s_we, ewe);
    for (int k = 0; k < waits; k++) begin
      s_rdata = $urandom;
      tick();
      check("wait_valid", s_valid, 1);
      check("wait_addr", s_addr, ea);
      check("wait_wdata", s_wdata, ew);
      check("wait_done", m_done, 0);
      scramble_masters();
    end
    s_ready = 1'b1;
    s_rdata = rd;
    tick();
    s_ready = 1'b0;
    s_rdata = $urandom;
    if (!ewe) model_rdata = rd;
    check("resp_valid", s_valid, 0);
    check("resp_done", m_done, bit_of(idx));
    check("resp_err", m_err, 0);
    check("resp_rdata", m_rdata, model_rdata);
    check("resp_busy", busy, 1);
    tick();
    check("idle_done", m_done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", s_valid, 0);
  endtask

  initial begin
    logic [NM-1:0] order [4];
    logic [NM-1:0] g;
    int k, last, cyc, cnt;

    reset = 1'b1; grant = '0; s_ready = 1'b0; s_rdata = '0; model_rdata = '0;
    scramble_masters();
    tick(); tick();
    check("rst_valid", s_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", m_done, 0);
    check("rst_err", m_err, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_addr", s_addr, 0);
    check("rst_wdata", s_wdata, 0);
    check("rst_we", s_we, 0);
    reset = 1'b0;
    tick();

    // Read from master 1, ready in first REQ cycle.
    addr_a[1] = 16'h0040; m_we[1] = 1'b0;
    xfer(4'b0010, 0, 32'hCAFE0001, 4'b0000);
    // Write from master 3 with delayed ready; m_rdata must hold.
    wdata_a[3] = 32'h12345678; m_we[3] = 1'b1;
    xfer(4'b1000, LONG_WAIT, $urandom, 4'b0000);
    // Multi-bit grant, then a grant raised during REQ served afterwards.
    xfer(4'b1010, 1, $urandom, 4'b0100);
    xfer(4'b0100, 0, $urandom, 4'b0000);

    for (int t = 0; t < 20; t++) begin
      g = 4'($urandom_range(1, 15));
      xfer(g, $urandom_range(0, 2), $urandom, 4'($urandom));
    end
    grant = '0;

    // Asynchronous reset in the middle of REQ.
    g = 4'b0001;
    grant = g;
    tick();
    grant = '0;
    check("mid_valid_pre", s_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_valid", s_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_done", m_done, 0);
    check("mid_rdata", m_rdata, 0);
    model_rdata = '0;
    s_ready = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("post_rst_done", m_done, 0);
      check("post_rst_busy", busy, 0);
    end
    s_ready = 1'b0;

`ifdef BUS_XFER_TIMEOUT_EN
    grant = 4'b0100;
    tick();
    grant = '0;
    cnt = 0;
    while (s_valid === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("to_valid_cycles", cnt, TO);
    check("to_done", m_done, 4'b0100);
    check("to_err", m_err, 4'b0100);
    check("to_rdata", m_rdata, 32'hFFFFFFFF);
    model_rdata = 32'hFFFFFFFF;
    tick();
    check("to_done_clr", m_done, 0);
    check("to_err_clr", m_err, 0);
`endif

    // Back-to-back with ready tied high: one completion every 3 cycles, in grant order.
    order[0] = 4'b0001; order[1] = 4'b0100; order[2] = 4'b1000; order[3] = 4'b0010;
    k = 0; last = -1; cyc = 0;
    grant = order[0];
    s_ready = 1'b1;
    while (k < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (m_done !== 4'b0000) begin
        check("b2b_order", m_done, order[k]);
        if (last >= 0) check("b2b_gap", cyc - last, 3);
        last = cyc;
        k++;
        grant = (k < 4) ? order[k] : 4'b0000;
      end
    end
    check("b2b_count", k, 4);
    s_ready = 1'b0;
    grant = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_xfer_mux.md
# bus_xfer_mux

Single-slave transaction stage that sits directly downstream of the round-robin bus arbiter. It consumes the arbiter's one-hot `grant` and latches the granted master's command (address, write data, direction). It drives that command to one shared slave over a valid/ready handshake, then returns read data and a one-cycle completion pulse to the owning master. `busy` lets the system hold off new grants while a transfer is in flight.

## Interface
Parameters:
- `NUM_MASTERS`, 4, number of masters; width of `grant`, `m_we`, `m_done`, `m_err`
- `ADDR_WIDTH`, 16, address width per master
- `DATA_WIDTH`, 32, data width per master and slave
- `TIMEOUT_CYCLES`, 15, slave-wait limit; only used with `BUS_XFER_TIMEOUT_EN`; legal range 1..255

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `grant`  in  NUM_MASTERS  one-hot grant from the arbiter
- `m_addr`  in  NUM_MASTERS*ADDR_WIDTH  flattened master addresses; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `m_wdata`  in  NUM_MASTERS*DATA_WIDTH  flattened master write data, packed the same way
- `m_we`  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read)
- `m_done`  out  NUM_MASTERS  one-cycle completion pulse to the owning master
- `m_err`  out  NUM_MASTERS  error flag, valid together with `m_done`
- `m_rdata`  out  DATA_WIDTH  read data, shared by all masters, valid while `m_done` is high
- `s_valid`  out  1  command valid to the slave
- `s_addr`  out  ADDR_WIDTH  captured address
- `s_wdata`  out  DATA_WIDTH  captured write data
- `s_we`  out  1  captured write enable
- `s_ready`  in  1  slave accepts and completes the command
- `s_rdata`  in  DATA_WIDTH  slave read data, valid when `s_ready` is high
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, REQ, RESP. All outputs are registered.
- IDLE:
  - If `grant` is nonzero at a clock edge, capture the owner index, `m_addr`, `m_wdata` and `m_we` for that index, then go to REQ.
  - If more than one `grant` bit is set, the lowest set index wins. No error is raised.
- REQ:
  - `s_valid`=1 and `s_addr`/`s_wdata`/`s_we` hold the captured values.
  - Changes on `grant` and on master inputs are ignored.
  - On an edge where `s_ready`=1: clear `s_valid`, capture `s_rdata` into `m_rdata` on reads (writes leave `m_rdata` unchanged), go to RESP.
- RESP: `m_done[idx]`=1 for exactly this one cycle, `m_err[idx]` per the Configuration section, then go to IDLE. `grant` is not sampled in RESP.
- `s_ready` is ignored outside REQ.
- Reset: state IDLE. `s_valid`, `s_addr`, `s_wdata`, `s_we`, `m_done`, `m_err`, `m_rdata` and `busy` are all 0.
- Reset mid-transfer: all outputs clear asynchronously, no `m_done` is issued, and the transfer is lost.

## Timing
- Grant sampled at edge N: `s_valid` and `busy` are high from cycle N+1.
- `s_ready` sampled high at edge M: `s_valid` is low and `m_done` is high in cycle M+1. The FSM is in IDLE in cycle M+2 and samples `grant` at edge M+2.
- Minimum transfer occupies 3 cycles (IDLE sample, REQ, RESP). Peak throughput is one transfer per 3 cycles.
- `s_valid` and the command fields are stable from assertion until the `s_ready` handshake edge.

## Configuration
- Macro: `BUS_XFER_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to REQ and increments every REQ cycle with `s_ready`=0.
  - When it reaches `TIMEOUT_CYCLES`, drop `s_valid` and go to RESP with `m_err[idx]`=1 and `m_rdata`=all-ones. This takes the same edge path as a handshake.
  - If `s_ready` is high on the timeout edge, the handshake wins and `m_err` stays 0.
- Not defined: REQ waits indefinitely, `m_err` is constant 0, and no counter is synthesized.

## Test plan
- Reset, then `grant`=0010 for 1 cycle, `m_addr[1]`=0x0040, read, `s_ready`=1 in the first REQ cycle with `s_rdata`=0xCAFE0001 -> `s_valid` high for 1 cycle with `s_addr`=0x0040, then `m_done`=0010 and `m_rdata`=0xCAFE0001 one cycle later.
- Write from master 3 (`m_wdata[3]`=0x12345678), `s_ready` delayed 4 cycles -> `s_valid` high for 5 cycles, `s_wdata` stable at 0x12345678, `m_done`=1000, `m_rdata` unchanged.
- `grant`=1010 in IDLE -> master 1 captured. New `grant`=0100 during REQ is ignored until IDLE, then master 2 is served with `s_valid` high 3 cycles after master 1's handshake edge.
- Assert `reset` while in REQ -> `s_valid`, `busy` and `m_done` go to 0 immediately, and no completion pulse follows deassertion.
- With `BUS_XFER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, hold `s_ready`=0 -> `s_valid` drops after 4 REQ cycles, `m_done[idx]`=1, `m_err[idx]`=1, `m_rdata`=0xFFFFFFFF.
- Back-to-back grants with `s_ready` tied 1 -> one `m_done` every 3 cycles, masters served in the order granted.
